// File: rtl/product_accumulator_if.sv
// Stream bus of the product accumulator: a product beat stream in, and a frame total
// out, each with its own valid/ready handshake.
interface product_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic [CNT_W-1:0]  beats;
    logic              overflow;

    modport slave (
        input  in_valid, product, in_last, out_ready,
        output in_ready, out_valid, sum, beats, overflow
    );

    modport master (
        output in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, sum, beats, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums a frame of up to COUNT unsigned multiplier products into an ACC_W-bit total and
// hands the total, beat count and sticky overflow downstream on a valid/ready port.
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int COUNT  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    product_accumulator_if.slave  bus
);
    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {ACCUM, DONE} state_t;

    state_t           state, state_nxt;
    logic             live;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum_q;
    logic [CNT_W-1:0] beats_q;
    logic [ACC_W:0]   acc_ext;
    logic             ready;
    logic             accept;
    logic             frame_end;
    logic             handshake;

    // Extra top bit of acc_ext is the carry out of the accumulator.
    assign acc_ext = {1'b0, acc} + {{(ACC_W - PROD_W + 1){1'b0}}, bus.product};

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        accept    = 1'b0;
        frame_end = 1'b0;
        handshake = 1'b0;
        case (state)
            ACCUM: begin
                ready  = live;
                accept = live & bus.in_valid & ~clear;
                if (accept && (bus.in_last || cnt == LAST_CNT)) begin
                    frame_end = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                handshake = bus.out_ready & ~clear;
                if (handshake) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
        if (clear) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            live  <= 1'b0;
        end else begin
            state <= state_nxt;
            live  <= 1'b1;
        end
    end

    // Running frame state; overflow stays visible through DONE until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            sum_q   <= '0;
            beats_q <= '0;
        end else if (clear || handshake) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= acc_ext[ACC_W-1:0];
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | acc_ext[ACC_W];
            if (frame_end) begin
                sum_q   <= acc_ext[ACC_W-1:0];
                beats_q <= cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.beats     = beats_q;
    assign bus.overflow  = ovf;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default 24-bit instance plus an 18-bit
// instance used for the wrap/overflow frame, both driven from one stimulus sequence.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clear = 1'b0;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(4)) b24 ();
    product_accumulator_if #(.PROD_W(16), .ACC_W(18), .CNT_W(4)) b18 ();

    assign b24.in_valid  = in_valid & ~sel;
    assign b24.product   = product;
    assign b24.in_last   = in_last;
    assign b24.out_ready = out_ready;
    assign b18.in_valid  = in_valid & sel;
    assign b18.product   = product;
    assign b18.in_last   = in_last;
    assign b18.out_ready = out_ready;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .COUNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b24.slave)
    );
    product_accumulator #(.PROD_W(16), .ACC_W(18), .COUNT(8)) dut18 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(b18.slave)
    );

    logic        o_valid, o_ready, o_ovf;
    logic [23:0] o_sum;
    logic [3:0]  o_beats;
    assign o_valid = sel ? b18.out_valid : b24.out_valid;
    assign o_ready = sel ? b18.in_ready  : b24.in_ready;
    assign o_ovf   = sel ? b18.overflow  : b24.overflow;
    assign o_sum   = sel ? {6'b0, b18.sum} : b24.sum;
    assign o_beats = sel ? b18.beats : b24.beats;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic last);
        in_valid = 1'b1;
        product  = p;
        in_last  = last;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] s, input logic [31:0] b,
                              input logic o);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_sum"}, 32'(o_sum), s);
        chk({tag, "_beats"}, 32'(o_beats), b);
        chk({tag, "_ovf"}, 32'(o_ovf), 32'(o));
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_sum", 32'(o_sum), 32'd0);
        chk("rst_beats", 32'(o_beats), 32'd0);
        chk("rst_ovf", 32'(o_ovf), 32'd0);
        #9 rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", 32'(o_ready), 32'd1);

        // 1: full frame of 255*255
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) beat(16'd65025, 1'b0);
        chk("t1_not_yet", 32'(o_valid), 32'd0);
        beat(16'd65025, 1'b0);
        chk_result("t1", 32'd520200, 32'd8, 1'b0);
        chk("t1_ready_done", 32'(o_ready), 32'd0);
        cyc();
        chk("t1_valid_drop", 32'(o_valid), 32'd0);
        chk("t1_ready_back", 32'(o_ready), 32'd1);

        // 2: early termination with in_last
        beat(16'd10, 1'b0);
        beat(16'd20, 1'b0);
        beat(16'd30, 1'b1);
        chk_result("t2", 32'd60, 32'd3, 1'b0);
        cyc();

        // 3: 18-bit accumulator wraps and flags overflow, next frame starts clean
        sel = 1'b1;
        for (int i = 0; i < 4; i++) beat(16'd65025, 1'b0);
        beat(16'd65025, 1'b1);
        chk_result("t3a", 32'd62981, 32'd5, 1'b1);
        cyc();
        beat(16'd7, 1'b1);
        chk_result("t3b", 32'd7, 32'd1, 1'b0);
        cyc();
        sel = 1'b0;

        // 4: backpressure holds result; held 99s are only taken after the handshake
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) beat(16'd1, 1'b0);
        in_valid = 1'b1;
        product  = 16'd99;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t4_hold_valid", 32'(o_valid), 32'd1);
            chk("t4_hold_sum", 32'(o_sum), 32'd8);
            chk("t4_hold_ready", 32'(o_ready), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("t4_hs_valid", 32'(o_valid), 32'd0);
        chk("t4_hs_ready", 32'(o_ready), 32'd1);
        in_last = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_result("t4b", 32'd99, 32'd1, 1'b0);
        cyc();

        // 5: clear drops the in-flight beat and partial sum
        for (int i = 0; i < 3; i++) beat(16'd100, 1'b0);
        clear = 1'b1;
        beat(16'd100, 1'b0);
        clear = 1'b0;
        chk("t5_clr_valid", 32'(o_valid), 32'd0);
        chk("t5_clr_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 7; i++) beat(16'd2, 1'b0);
        beat(16'd2, 1'b1);
        chk_result("t5", 32'd16, 32'd8, 1'b0);
        cyc();
        chk("t5_single_end", 32'(o_valid), 32'd0);

        // 5b: clear while a result is pending discards it
        out_ready = 1'b0;
        beat(16'd40, 1'b1);
        chk("t5b_pending", 32'(o_valid), 32'd1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5b_killed", 32'(o_valid), 32'd0);
        out_ready = 1'b1;
        beat(16'd5, 1'b1);
        chk_result("t5b", 32'd5, 32'd1, 1'b0);
        cyc();

        // 6: asynchronous reset mid-frame
        beat(16'd3, 1'b0);
        beat(16'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_sum", 32'(o_sum), 32'd0);
        chk("t6_rst_beats", 32'(o_beats), 32'd0);
        chk("t6_rst_valid", 32'(o_valid), 32'd0);
        chk("t6_rst_ready", 32'(o_ready), 32'd0);
        #2 rst_n = 1'b1;
        cyc();
        chk("t6_ready", 32'(o_ready), 32'd1);
        for (int i = 0; i < 8; i++) beat(16'd3, 1'b0);
        chk_result("t6", 32'd24, 32'd8, 1'b0);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
